// File: rtl/mem_bus.sv
// mem_bus: CPU-side slave decoding RAM, a FIFO-backed 8N1 UART transmitter and an LED register.
module mem_bus #(
  parameter int RAM_WORDS = 4096,
  parameter int CLK_DIV   = 104
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic [15:0] addr,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_mask,
  output logic        uart_tx,
  output logic [7:0]  led
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam int CW = $clog2(CLK_DIV);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  logic [31:0]   r_mem [RAM_WORDS];
  logic [7:0]    r_fifo [4];
  logic [31:0]   r_ram_q, r_other;
  logic          r_ram_sel, r_valid, r_ovf, r_tx;
  logic [7:0]    r_led, r_shift;
  logic [2:0]    r_wp, r_rp, r_idx;
  logic [CW-1:0] r_cnt;
  state_t        r_st;
  logic [AW-1:0] w_idx;
  logic          w_ram, w_udat, w_ustat, w_led, w_rd, w_full, w_empty;
  logic          w_push, w_pop, w_busy, w_last, w_unused;
  logic [31:0]   w_other;
  assign w_idx    = addr[AW+1:2];
  assign w_ram    = ~addr[15];
  assign w_udat   = addr[15:2] == 14'h2000;
  assign w_ustat  = addr[15:2] == 14'h2001;
  assign w_led    = addr[15:2] == 14'h2002;
  assign w_rd     = rd_en & ~wr_en;
  assign w_full   = (r_wp - r_rp) == 3'd4;
  assign w_empty  = r_wp == r_rp;
  assign w_push   = wr_en & w_udat & wr_mask[3];
  assign w_pop    = (r_st == IDLE) & ~w_empty;
  assign w_busy   = (r_st != IDLE) | ~w_empty;
  assign w_last   = r_cnt == CW'(CLK_DIV - 1);
  assign w_other  = w_ustat ? {29'b0, r_ovf, w_busy, w_full} : w_led ? {24'b0, r_led} : 32'b0;
  assign w_unused = ^addr[1:0];
  assign rd_data  = r_ram_sel ? r_ram_q : r_other;
  assign rd_valid = r_valid;
  assign uart_tx  = r_tx;
  assign led      = r_led;
  // Storage without reset so the RAM maps onto block RAM with a plain output register
  always_ff @(posedge clk) begin
    if (w_rd & w_ram) r_ram_q <= r_mem[w_idx];
    for (int k = 0; k < 4; k++)
      if (wr_en & w_ram & wr_mask[3-k]) r_mem[w_idx][8*k +: 8] <= wr_data[8*k +: 8];
    if (w_push & ~w_full) r_fifo[r_wp[1:0]] <= wr_data[7:0];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_ram_sel <= 1'b0;
      r_other   <= '0;
      r_led     <= '0;
      r_wp      <= '0;
      r_rp      <= '0;
      r_ovf     <= 1'b0;
      r_st      <= IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
    end else begin
      r_valid <= w_rd;
      if (w_rd) begin
        r_ram_sel <= w_ram;
        r_other   <= w_other;
      end
      if (wr_en & w_led & wr_mask[3]) r_led <= wr_data[7:0];
      if (w_push & ~w_full) r_wp <= r_wp + 3'd1;
      // a status read clears overflow unless this same cycle overflows again
      r_ovf <= (w_push & w_full) | (r_ovf & ~(w_rd & w_ustat));
      r_cnt <= (r_st == IDLE || w_last) ? '0 : r_cnt + 1'b1;
      case (r_st)
        IDLE: if (w_pop) begin
          r_shift <= r_fifo[r_rp[1:0]];
          r_rp    <= r_rp + 3'd1;
          r_tx    <= 1'b0;
          r_st    <= START;
        end
        START: if (w_last) begin
          r_idx <= '0;
          r_tx  <= r_shift[0];
          r_st  <= DATA;
        end
        DATA: if (w_last) begin
          if (r_idx == 3'd7) begin
            r_tx <= 1'b1;
            r_st <= STOP;
          end else begin
            r_idx   <= r_idx + 3'd1;
            r_shift <= r_shift >> 1;
            r_tx    <= r_shift[1];
          end
        end
        default: if (w_last) r_st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_bus.sv
// tb_mem_bus: random and directed stimulus against a behavioural model, with scoreboards for reads and UART bytes.
module tb_mem_bus;
  localparam int RW = 256;
  localparam int CD = 4;
  logic        clk = 0, rst = 0, rd_en = 0, wr_en = 0;
  logic [15:0] addr = 0;
  logic [31:0] wr_data = 0;
  logic [3:0]  wr_mask = 0;
  logic [31:0] rd_data;
  logic        rd_valid, uart_tx;
  logic [7:0]  led;
  int          checks = 0, errors = 0;
  logic [31:0] q_exp [$];
  logic [7:0]  q_tx [$];
  logic [31:0] m_ram [RW];
  logic [7:0]  m_led = 0;
  logic        rx_go = 0;
  logic [31:0] mon_e;
  logic [7:0]  rx_b, rx_e;
  logic        rx_stop;
  logic [7:0]  ob [6];

  mem_bus #(.RAM_WORDS(RW), .CLK_DIV(CD)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .addr(addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_en(wr_en), .wr_data(wr_data), .wr_mask(wr_mask), .uart_tx(uart_tx), .led(led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [15:0] a);
    if (a < 16'h8000) return m_ram[(int'(a) >> 2) % RW];
    if ((a & 16'hFFFC) == 16'h8008) return {24'b0, m_led};
    return 32'b0;
  endfunction

  task automatic model_wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] m);
    int idx;
    idx = (int'(a) >> 2) % RW;
    if (a < 16'h8000) begin
      for (int k = 0; k < 4; k++) if (m[3-k]) m_ram[idx][8*k +: 8] = d[8*k +: 8];
    end else if ((a & 16'hFFFC) == 16'h8008 && m[3]) m_led = d[7:0];
  endtask

  task automatic op(input bit rd, input bit wr, input logic [15:0] a, input logic [31:0] d, input logic [3:0] m);
    rd_en = rd; wr_en = wr; addr = a; wr_data = d; wr_mask = m;
    if (rd && !wr) q_exp.push_back(model_rd(a));
    if (wr) model_wr(a, d, m);
    @(posedge clk); #1;
    rd_en = 0; wr_en = 0;
  endtask

  task automatic sread(input logic [31:0] exp);
    rd_en = 1; wr_en = 0; addr = 16'h8004;
    q_exp.push_back(exp);
    @(posedge clk); #1;
    rd_en = 0;
  endtask

  always @(negedge clk) begin
    if (!rst && rd_valid) begin
      checks++;
      if (q_exp.size() == 0) begin
        errors++;
        $display("FAIL rd_valid unexpected, rd_data %h", rd_data);
      end else begin
        mon_e = q_exp.pop_front();
        if (rd_data !== mon_e) begin
          errors++;
          $display("FAIL read_data got %h expected %h", rd_data, mon_e);
        end
      end
    end
  end

  // Serial receiver: samples each bit near its centre
  initial begin
    wait (rx_go);
    forever begin
      @(negedge clk);
      if (uart_tx === 1'b0) begin
        repeat (CD + CD/2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          rx_b[i] = uart_tx;
          if (i < 7) repeat (CD) @(negedge clk);
        end
        repeat (CD) @(negedge clk);
        rx_stop = uart_tx;
        checks++;
        if (q_tx.size() == 0) begin
          errors++;
          $display("FAIL uart_frame unexpected byte got %h", rx_b);
        end else begin
          rx_e = q_tx.pop_front();
          if (rx_b !== rx_e || rx_stop !== 1'b1) begin
            errors++;
            $display("FAIL uart_frame got %h stop %b expected %h stop 1", rx_b, rx_stop, rx_e);
          end
        end
      end
    end
  end

  function automatic logic frame_bit(input logic [7:0] b, input int j);
    int s;
    s = j / CD;
    if (s == 0) return 1'b0;
    if (s == 9) return 1'b1;
    return b[s-1];
  endfunction

  initial begin
    logic [15:0] a;
    logic [7:0]  ub;
    #2 rst = 1;
    #1;
    chk("reset rd_valid", rd_valid, 0);
    chk("reset rd_data", rd_data, 0);
    chk("reset uart_tx", uart_tx, 1);
    chk("reset led", led, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 0;
    @(posedge clk); #1;
    // asynchronous reset in the middle of a cycle and of a frame
    op(0, 1, 16'h8008, 32'hFF, 4'b1000);
    op(0, 1, 16'h8000, 32'h3C, 4'b1000);
    rd_en = 1; addr = 16'h8008;
    @(posedge clk); #1;
    rd_en = 0;
    chk("pre-reset start bit", uart_tx, 0);
    chk("pre-reset rd_valid", rd_valid, 1);
    chk("pre-reset rd_data", rd_data, 32'hFF);
    #1 rst = 1;
    #1;
    chk("async rd_valid", rd_valid, 0);
    chk("async rd_data", rd_data, 0);
    chk("async uart_tx", uart_tx, 1);
    chk("async led", led, 0);
    m_led = 0;
    @(negedge clk) rst = 0;
    @(posedge clk); #1;
    sread(32'h0);
    repeat (3) @(posedge clk);
    #1 chk("idle after reset", uart_tx, 1);
    rx_go = 1;
    for (int i = 0; i < RW; i++) op(0, 1, 16'(i * 4), $urandom, 4'hF);
    // RAM full and byte-lane writes
    op(0, 1, 16'h0010, 32'h11223344, 4'hF);
    op(1, 0, 16'h0010, 0, 0);
    chk("word rd_valid", rd_valid, 1);
    chk("word rd_data", rd_data, 32'h11223344);
    op(0, 1, 16'h0010, 32'h0000AA00, 4'b0100);
    op(1, 0, 16'h0010, 0, 0);
    chk("lane rd_data", rd_data, 32'h1122AA44);
    op(1, 0, 16'h0010 + 16'(RW * 4), 0, 0);
    // simultaneous read and write: write wins, read data held
    op(1, 1, 16'h0020, 32'hDEADBEEF, 4'hF);
    chk("conflict rd_valid", rd_valid, 0);
    chk("conflict rd_data held", rd_data, 32'h1122AA44);
    op(1, 0, 16'h0020, 0, 0);
    // LED and unmapped space
    op(0, 1, 16'h8008, 32'hA5, 4'b1000);
    chk("led value", led, 32'hA5);
    op(1, 0, 16'h8008, 0, 0);
    op(0, 1, 16'h9000, 32'h12345678, 4'hF);
    chk("led after unmapped write", led, 32'hA5);
    op(1, 0, 16'h9000, 0, 0);
    op(1, 0, 16'h8000, 0, 0);
    // single UART frame, cycle by cycle
    q_tx.push_back(8'h55);
    op(0, 1, 16'h8000, 32'h55, 4'b1000);
    chk("tx before start", uart_tx, 1);
    sread(32'h2);
    for (int j = 0; j < 10 * CD; j++) begin
      chk("tx frame bit", uart_tx, frame_bit(8'h55, j));
      if (j == 20) sread(32'h2);
      else begin @(posedge clk); #1; end
    end
    chk("tx after frame", uart_tx, 1);
    sread(32'h0);
    // FIFO overflow: six pushes, one taken, four queued, one dropped
    for (int i = 0; i < 6; i++) ob[i] = 8'($urandom);
    for (int i = 0; i < 5; i++) q_tx.push_back(ob[i]);
    for (int i = 0; i < 6; i++) op(0, 1, 16'h8000, {24'h0, ob[i]}, 4'b1000);
    sread(32'h7);
    sread(32'h3);
    for (int i = 0; i < 800 && q_tx.size() != 0; i++) @(posedge clk);
    #1 chk("uart frames done", q_tx.size(), 0);
    repeat (CD + 50) @(posedge clk);
    #1 sread(32'h0);
    // random traffic over RAM, LED, UART data reads and unmapped space
    for (int i = 0; i < 400; i++) begin
      int kind;
      bit rd, wr;
      kind = $urandom_range(0, 9);
      a = kind < 6 ? 16'($urandom_range(0, 16'h7FFF)) :
          kind == 6 ? 16'h8008 | 16'($urandom_range(0, 3)) :
          kind == 7 ? 16'h8000 :
          kind == 8 ? 16'h9000 + 16'($urandom_range(0, 16'h6FFF)) :
                      16'h800C + 16'($urandom_range(0, 16'h7FF0));
      rd = 1'($urandom);
      wr = kind == 7 ? 1'b0 : 1'($urandom);
      if (!rd && !wr) rd = 1;
      ub = 8'($urandom);
      op(rd, wr, a, {$urandom_range(0, 32'hFFFFFF), ub}[31:0], 4'($urandom));
    end
    #1 chk("led final", led, {24'b0, m_led});
    repeat (3) @(posedge clk);
    #1;
    chk("read scoreboard drained", q_exp.size(), 0);
    chk("uart scoreboard drained", q_tx.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
